// File: rtl/ikaopll_pkg.sv
// ikaopll_pkg
// Shared definitions for the OPLL host-side bus writer and its helpers:
//   bus_state_t  - 4-bit write-sequence state encoding
//   opll_req_t   - 16-bit queued write request {addr, data}
//   OPLL_ADDR_WAIT / OPLL_DATA_WAIT - default phiM idle times after strobes
package ikaopll_pkg;

   localparam int OPLL_ADDR_WAIT = 12;
   localparam int OPLL_DATA_WAIT = 84;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_A_SETUP  = 4'd1,
      ST_A_STROBE = 4'd2,
      ST_A_HOLD   = 4'd3,
      ST_A_WAIT   = 4'd4,
      ST_D_SETUP  = 4'd5,
      ST_D_STROBE = 4'd6,
      ST_D_HOLD   = 4'd7,
      ST_D_WAIT   = 4'd8
   } bus_state_t;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } opll_req_t;

endpackage

// File: rtl/ikaopll_bus_writer_fifo.sv
// ikaopll_bus_writer_fifo
// Synchronous show-ahead FIFO of 16-bit words with asynchronous active-low reset.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   push / wr_data - write a word (ignored when full)
//   pop  / rd_data - rd_data is the head word; pop discards it (ignored when empty)
//   level          - occupied entries, 0..DEPTH
//   full, empty    - status flags
module ikaopll_bus_writer_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [15:0]              wr_data,
   output logic [15:0]              rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_L = DEPTH[PTR_W:0];

   logic [15:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == DEPTH_L);
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      level <= level + 1'b1;
         else if (do_pop && !do_push) level <= level - 1'b1;
      end
   end

endmodule

// File: rtl/ikaopll_bus_writer.sv
// ikaopll_bus_writer
// Host-side initiator for the OPLL CPU write bus. Queues (addr, data) requests
// and replays each as an address strobe followed by a data strobe, with all
// timing counted in phiM ticks.
// Ports:
//   i_EMUCLK, i_RST_n        - clock, async active-low reset
//   i_phiM_PCEN_n            - phiM tick enable, active low
//   i_REQ_VALID/ADDR/DATA    - request input; o_REQ_READY = FIFO not full
//   o_FIFO_LEVEL, o_BUSY     - queue occupancy, activity flag
//   o_CS_n, o_WR_n, o_A0, o_D - OPLL write bus
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | bus idle, pop next request on a tick
// A_SETUP   | drive A0=0, D=addr for 1 tick, record last address
// A_STROBE  | CS_n/WR_n low for WR_PULSE ticks
// A_HOLD    | strobe released, A0/D held, 1 tick
// A_WAIT    | ADDR_WAIT idle ticks
// D_SETUP   | drive A0=1, D=data for 1 tick
// D_STROBE  | CS_n/WR_n low for WR_PULSE ticks
// D_HOLD    | strobe released, 1 tick
// D_WAIT    | DATA_WAIT idle ticks, then IDLE
module ikaopll_bus_writer
   import ikaopll_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int WR_PULSE       = 2,
   parameter int ADDR_WAIT      = OPLL_ADDR_WAIT,
   parameter int DATA_WAIT      = OPLL_DATA_WAIT,
   parameter bit SKIP_SAME_ADDR = 1'b0
) (
   input  logic                           i_EMUCLK,
   input  logic                           i_RST_n,
   input  logic                           i_phiM_PCEN_n,
   input  logic                           i_REQ_VALID,
   input  logic [7:0]                     i_REQ_ADDR,
   input  logic [7:0]                     i_REQ_DATA,
   output logic                           o_REQ_READY,
   output logic [$clog2(FIFO_DEPTH):0]    o_FIFO_LEVEL,
   output logic                           o_BUSY,
   output logic                           o_CS_n,
   output logic                           o_WR_n,
   output logic                           o_A0,
   output logic [7:0]                     o_D
);

   // Counters load N-1 on state entry and leave the state on the tick they read 0.
   localparam logic [7:0] PULSE_LD = 8'(WR_PULSE - 1);
   localparam logic [7:0] AWAIT_LD = 8'(ADDR_WAIT - 1);
   localparam logic [7:0] DWAIT_LD = 8'(DATA_WAIT - 1);

   bus_state_t state;
   logic [7:0] cnt;
   opll_req_t  work;
   opll_req_t  head;
   logic [7:0] last_addr;
   logic       last_valid;
   logic       tick;
   logic       fifo_push;
   logic       fifo_pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic [15:0] fifo_rd;

   assign tick        = ~i_phiM_PCEN_n;
   assign fifo_push   = i_REQ_VALID & ~fifo_full;
   assign fifo_pop    = tick & (state == ST_IDLE) & ~fifo_empty;
   assign head        = opll_req_t'(fifo_rd);
   assign o_REQ_READY = ~fifo_full;
   assign o_BUSY      = (state != ST_IDLE) | ~fifo_empty;

   ikaopll_bus_writer_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (i_EMUCLK),
      .rst_n   (i_RST_n),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_data ({i_REQ_ADDR, i_REQ_DATA}),
      .rd_data (fifo_rd),
      .level   (o_FIFO_LEVEL),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         work       <= '0;
         last_addr  <= '0;
         last_valid <= 1'b0;
         o_CS_n     <= 1'b1;
         o_WR_n     <= 1'b1;
         o_A0       <= 1'b0;
         o_D        <= '0;
      end else if (tick) begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  work <= head;
                  if (SKIP_SAME_ADDR && last_valid && (head.addr == last_addr))
                     state <= ST_D_SETUP;
                  else
                     state <= ST_A_SETUP;
               end
            end
            ST_A_SETUP: begin
               o_A0       <= 1'b0;
               o_D        <= work.addr;
               last_addr  <= work.addr;
               last_valid <= 1'b1;
               cnt        <= PULSE_LD;
               state      <= ST_A_STROBE;
            end
            ST_A_STROBE: begin
               o_CS_n <= 1'b0;
               o_WR_n <= 1'b0;
               if (cnt == '0) state <= ST_A_HOLD;
               else           cnt   <= cnt - 1'b1;
            end
            ST_A_HOLD: begin
               o_CS_n <= 1'b1;
               o_WR_n <= 1'b1;
               cnt    <= AWAIT_LD;
               state  <= ST_A_WAIT;
            end
            ST_A_WAIT: begin
               if (cnt == '0) state <= ST_D_SETUP;
               else           cnt   <= cnt - 1'b1;
            end
            ST_D_SETUP: begin
               o_A0  <= 1'b1;
               o_D   <= work.data;
               cnt   <= PULSE_LD;
               state <= ST_D_STROBE;
            end
            ST_D_STROBE: begin
               o_CS_n <= 1'b0;
               o_WR_n <= 1'b0;
               if (cnt == '0) state <= ST_D_HOLD;
               else           cnt   <= cnt - 1'b1;
            end
            ST_D_HOLD: begin
               o_CS_n <= 1'b1;
               o_WR_n <= 1'b1;
               cnt    <= DWAIT_LD;
               state  <= ST_D_WAIT;
            end
            ST_D_WAIT: begin
               if (cnt == '0) state <= ST_IDLE;
               else           cnt   <= cnt - 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ikaopll_bus_writer.sv
// tb_ikaopll_bus_writer
// Bench for ikaopll_bus_writer. Three instances cover the default timing,
// same-address skipping, and minimum counts. A monitor turns the selected
// instance's bus into a list of strobes (tick of CS_n fall/rise, A0, D); each
// scenario compares that list with a schedule computed from the request list.
module tb_ikaopll_bus_writer;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
   } req_t;

   typedef struct {
      int         fall;
      int         rise;
      int         fclk;
      int         rclk;
      logic       a0;
      logic [7:0] d;
   } strobe_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             pcen_n = 1'b1;
   logic [2:0]       valid = '0;
   logic [2:0][7:0]  addr = '0;
   logic [2:0][7:0]  data = '0;
   logic [2:0]       ready;
   logic [2:0]       busy;
   logic [2:0]       cs_n;
   logic [2:0]       wr_n;
   logic [2:0]       a0;
   logic [2:0][7:0]  dq;
   logic [2:0][2:0]  lvl;

   int errors = 0;
   int checks = 0;
   int sel = 0;
   int tick_div = 1;
   int clk_cnt = 0;
   int tick_no = 0;
   int edge_no = 0;
   bit last_tick = 0;
   int busy_fall = -1;
   int nontick_viol = 0;
   int split_viol = 0;

   strobe_t obs[$];
   strobe_t exp_q[$];
   req_t    req_q[$];

   always #5 clk = ~clk;

   ikaopll_bus_writer #(.FIFO_DEPTH(4)) dut0 (
      .i_EMUCLK(clk), .i_RST_n(rst_n), .i_phiM_PCEN_n(pcen_n),
      .i_REQ_VALID(valid[0]), .i_REQ_ADDR(addr[0]), .i_REQ_DATA(data[0]),
      .o_REQ_READY(ready[0]), .o_FIFO_LEVEL(lvl[0]), .o_BUSY(busy[0]),
      .o_CS_n(cs_n[0]), .o_WR_n(wr_n[0]), .o_A0(a0[0]), .o_D(dq[0]));

   ikaopll_bus_writer #(.FIFO_DEPTH(4), .SKIP_SAME_ADDR(1'b1)) dut1 (
      .i_EMUCLK(clk), .i_RST_n(rst_n), .i_phiM_PCEN_n(pcen_n),
      .i_REQ_VALID(valid[1]), .i_REQ_ADDR(addr[1]), .i_REQ_DATA(data[1]),
      .o_REQ_READY(ready[1]), .o_FIFO_LEVEL(lvl[1]), .o_BUSY(busy[1]),
      .o_CS_n(cs_n[1]), .o_WR_n(wr_n[1]), .o_A0(a0[1]), .o_D(dq[1]));

   ikaopll_bus_writer #(.FIFO_DEPTH(4), .WR_PULSE(1), .ADDR_WAIT(1), .DATA_WAIT(1)) dut2 (
      .i_EMUCLK(clk), .i_RST_n(rst_n), .i_phiM_PCEN_n(pcen_n),
      .i_REQ_VALID(valid[2]), .i_REQ_ADDR(addr[2]), .i_REQ_DATA(data[2]),
      .o_REQ_READY(ready[2]), .o_FIFO_LEVEL(lvl[2]), .o_BUSY(busy[2]),
      .o_CS_n(cs_n[2]), .o_WR_n(wr_n[2]), .o_A0(a0[2]), .o_D(dq[2]));

   // Tick enable, changed on the falling edge so it is stable at the rising edge.
   always @(negedge clk) begin
      clk_cnt++;
      pcen_n = !(tick_div != 0 && (clk_cnt % tick_div) == 0);
   end

   always @(posedge clk) begin
      edge_no++;
      last_tick = !pcen_n;
      if (!pcen_n) tick_no++;
   end

   // Bus monitor on the selected instance, sampled on the falling edge.
   logic       p_cs = 1'b1, p_wr = 1'b1, p_a0 = 1'b0, p_busy = 1'b0;
   logic [7:0] p_d = '0;
   strobe_t    cur;
   always @(negedge clk) begin
      logic       m_cs, m_wr, m_a0, m_busy;
      logic [7:0] m_d;
      m_cs = cs_n[sel]; m_wr = wr_n[sel]; m_a0 = a0[sel]; m_d = dq[sel]; m_busy = busy[sel];
      if (rst_n) begin
         if (m_cs !== m_wr) split_viol++;
         if (!last_tick && {m_cs, m_wr, m_a0, m_d} !== {p_cs, p_wr, p_a0, p_d}) nontick_viol++;
         if (p_cs && !m_cs) begin
            cur.fall = tick_no; cur.fclk = edge_no; cur.a0 = m_a0; cur.d = m_d;
         end
         if (!p_cs && m_cs) begin
            cur.rise = tick_no; cur.rclk = edge_no;
            obs.push_back(cur);
         end
         if (p_busy && !m_busy) busy_fall = tick_no;
      end
      p_cs = m_cs; p_wr = m_wr; p_a0 = m_a0; p_d = m_d; p_busy = m_busy;
   end

   // Reference schedule: each request occupies one IDLE tick, an optional
   // address phase (setup + pulse + hold + wait) and a data phase. Returns
   // the tick on which the writer is back in IDLE with nothing left.
   function automatic int build_expect(int s0, int wp, int aw, int dw, bit skip_en);
      int         s = s0;
      bit         lv = 0;
      logic [7:0] la = '0;
      int         alen;
      bit         skip;
      strobe_t    e;
      exp_q.delete();
      foreach (req_q[i]) begin
         skip = skip_en && lv && (req_q[i].a == la);
         alen = skip ? 0 : 2 + wp + aw;
         if (!skip) begin
            e.fall = s + 2; e.rise = s + 2 + wp; e.a0 = 1'b0; e.d = req_q[i].a;
            e.fclk = 0; e.rclk = 0;
            exp_q.push_back(e);
         end
         e.fall = s + 2 + alen; e.rise = s + 2 + alen + wp; e.a0 = 1'b1; e.d = req_q[i].d;
         e.fclk = 0; e.rclk = 0;
         exp_q.push_back(e);
         s = s + 1 + alen + 2 + wp + dw;
         lv = 1; la = req_q[i].a;
      end
      return s - 1;
   endfunction

   task automatic do_reset(input int s);
      @(negedge clk); #2;
      rst_n = 1'b0;
      valid = '0;
      sel = s;
      tick_div = 1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      obs.delete();
      req_q.delete();
      busy_fall = -1;
      nontick_viol = 0;
      split_viol = 0;
      @(negedge clk);
   endtask

   // Starts at a falling edge; returns at the falling edge after acceptance.
   task automatic push_req(input int k, input logic [7:0] a, input logic [7:0] d, output int ptick);
      logic r;
      int   guard = 0;
      #1;
      valid[k] = 1'b1; addr[k] = a; data[k] = d;
      forever begin
         r = ready[k];
         @(negedge clk);
         if (r) break;
         guard++;
         if (guard > 2000) begin
            checks++; errors++;
            $display("FAIL push_timeout: ready still %0b after %0d clocks, required 1", ready[k], guard);
            break;
         end
      end
      ptick = tick_no;
      valid[k] = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy[sel] !== 1'b0) begin
         @(negedge clk);
         n++;
         if (n > limit) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy=%0b after %0d clocks, required 0", busy[sel], n);
            break;
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset(0);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({cs_n[k], wr_n[k], a0[k], dq[k], lvl[k], ready[k], busy[k]} !== {1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state dut%0d: got cs=%0b wr=%0b a0=%0b d=%02h lvl=%0d rdy=%0b busy=%0b, required 1 1 0 00 0 1 0",
                     k, cs_n[k], wr_n[k], a0[k], dq[k], lvl[k], ready[k], busy[k]);
         end
      end
   endtask

   task automatic test_single();
      int p, done;
      do_reset(0);
      push_req(0, 8'h10, 8'h55, p);
      req_q.push_back('{8'h10, 8'h55});
      done = build_expect(p + 1, 2, 12, 84, 0);
      wait_idle(400);
      checks++;
      if (obs.size() !== 2) begin
         errors++; $display("FAIL single_count: got %0d strobes, required 2", obs.size());
      end else begin
         checks++;
         if (obs[0].fall - p !== 3 || obs[0].rise - p !== 5 || obs[1].fall - p !== 19 || obs[1].rise - p !== 21) begin
            errors++;
            $display("FAIL single_ticks: got %0d-%0d / %0d-%0d, required 3-5 / 19-21",
                     obs[0].fall - p, obs[0].rise - p, obs[1].fall - p, obs[1].rise - p);
         end
      end
      checks++;
      if (busy_fall - p !== 105 || busy_fall !== done) begin
         errors++; $display("FAIL single_busy: got busy drop at +%0d, required +105", busy_fall - p);
      end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs[i].fall !== exp_q[i].fall || obs[i].rise !== exp_q[i].rise || obs[i].a0 !== exp_q[i].a0 || obs[i].d !== exp_q[i].d) begin
            errors++;
            $display("FAIL single_strobe%0d: got %0d-%0d a0=%0b d=%02h, required %0d-%0d a0=%0b d=%02h", i,
                     obs[i].fall, obs[i].rise, obs[i].a0, obs[i].d, exp_q[i].fall, exp_q[i].rise, exp_q[i].a0, exp_q[i].d);
         end
      end
   endtask

   task automatic test_back_to_back();
      int   p, p5, s0, done;
      req_t r;
      do_reset(0);
      tick_div = 0;
      for (int i = 0; i < 5; i++) begin
         r.a = 8'($urandom_range(0, 255)); r.d = 8'($urandom_range(0, 255));
         req_q.push_back(r);
      end
      for (int i = 0; i < 4; i++) push_req(0, req_q[i].a, req_q[i].d, p);
      s0 = 0;
      fork
         push_req(0, req_q[4].a, req_q[4].d, p5);
         begin
            repeat (4) @(negedge clk);
            #2;
            checks++;
            if (ready[0] !== 1'b0 || lvl[0] !== 3'd4) begin
               errors++; $display("FAIL b2b_full: got ready=%0b level=%0d, required 0 4", ready[0], lvl[0]);
            end
            s0 = tick_no + 1;
            tick_div = 1;
         end
      join
      checks++;
      if (p5 !== s0 + 1 || lvl[0] !== 3'd4) begin
         errors++; $display("FAIL b2b_fifth: accepted at tick %0d level %0d, required %0d level 4", p5, lvl[0], s0 + 1);
      end
      done = build_expect(s0, 2, 12, 84, 0);
      wait_idle(1000);
      checks++;
      if (obs.size() !== exp_q.size() || busy_fall !== done) begin
         errors++; $display("FAIL b2b_count: got %0d strobes busy drop %0d, required %0d and %0d", obs.size(), busy_fall, exp_q.size(), done);
      end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs[i].fall !== exp_q[i].fall || obs[i].rise !== exp_q[i].rise || obs[i].a0 !== exp_q[i].a0 || obs[i].d !== exp_q[i].d) begin
            errors++;
            $display("FAIL b2b_strobe%0d: got %0d-%0d a0=%0b d=%02h, required %0d-%0d a0=%0b d=%02h", i,
                     obs[i].fall, obs[i].rise, obs[i].a0, obs[i].d, exp_q[i].fall, exp_q[i].rise, exp_q[i].a0, exp_q[i].d);
         end
      end
   endtask

   task automatic test_skip();
      int         p, p0, done;
      logic [7:0] ad [7];
      ad[0] = 8'h20; ad[1] = 8'h20; ad[2] = 8'h21;
      for (int i = 3; i < 7; i++) ad[i] = 8'($urandom_range(8'h30, 8'h31));
      do_reset(1);
      p0 = 0;
      // Seven requests through a 4-deep queue: later pushes wait on ready.
      for (int i = 0; i < 7; i++) begin
         req_q.push_back('{ad[i], 8'($urandom_range(0, 255))});
         push_req(1, req_q[i].a, req_q[i].d, p);
         if (i == 0) p0 = p;
      end
      done = build_expect(p0 + 1, 2, 12, 84, 1);
      wait_idle(2000);
      checks++;
      if (obs.size() < 5 || obs[2].a0 !== 1'b1 || obs[2].fall - obs[1].fall !== 89 || obs[3].a0 !== 1'b0) begin
         errors++; $display("FAIL skip_second: got %0d strobes, third strobe a0=%0b spacing %0d, required a0=1 spacing 89",
                            obs.size(), obs[2].a0, obs[2].fall - obs[1].fall);
      end
      checks++;
      if (obs.size() !== exp_q.size() || busy_fall !== done) begin
         errors++; $display("FAIL skip_count: got %0d strobes busy drop %0d, required %0d and %0d", obs.size(), busy_fall, exp_q.size(), done);
      end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs[i].fall !== exp_q[i].fall || obs[i].rise !== exp_q[i].rise || obs[i].a0 !== exp_q[i].a0 || obs[i].d !== exp_q[i].d) begin
            errors++;
            $display("FAIL skip_strobe%0d: got %0d-%0d a0=%0b d=%02h, required %0d-%0d a0=%0b d=%02h", i,
                     obs[i].fall, obs[i].rise, obs[i].a0, obs[i].d, exp_q[i].fall, exp_q[i].rise, exp_q[i].a0, exp_q[i].d);
         end
      end
   endtask

   task automatic test_scaled();
      int p, p0, done;
      do_reset(0);
      tick_div = 4;
      p0 = 0;
      for (int i = 0; i < 2; i++) begin
         req_q.push_back('{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))});
         push_req(0, req_q[i].a, req_q[i].d, p);
         if (i == 0) p0 = p;
      end
      done = build_expect(p0 + 1, 2, 12, 84, 0);
      wait_idle(2000);
      checks++;
      if (nontick_viol !== 0 || split_viol !== 0) begin
         errors++; $display("FAIL scaled_pins: got %0d non-tick changes %0d cs/wr splits, required 0 0", nontick_viol, split_viol);
      end
      checks++;
      if (obs.size() !== exp_q.size() || busy_fall !== done) begin
         errors++; $display("FAIL scaled_count: got %0d strobes busy drop %0d, required %0d and %0d", obs.size(), busy_fall, exp_q.size(), done);
      end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs[i].fall !== exp_q[i].fall || obs[i].rise !== exp_q[i].rise || obs[i].d !== exp_q[i].d ||
             obs[i].rclk - obs[i].fclk !== 8) begin
            errors++;
            $display("FAIL scaled_strobe%0d: got tick %0d-%0d d=%02h width %0d clocks, required %0d-%0d d=%02h width 8", i,
                     obs[i].fall, obs[i].rise, obs[i].d, obs[i].rclk - obs[i].fclk, exp_q[i].fall, exp_q[i].rise, exp_q[i].d);
         end
      end
   endtask

   task automatic test_reset_mid();
      int p, n;
      do_reset(0);
      for (int i = 0; i < 3; i++) push_req(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), p);
      n = 0;
      while (!(cs_n[0] === 1'b0 && a0[0] === 1'b1) && n < 200) begin
         @(negedge clk); n++;
      end
      checks++;
      if (n >= 200 || lvl[0] !== 3'd2) begin
         errors++; $display("FAIL rstmid_reach: data strobe after %0d clocks level %0d, required within 200 and level 2", n, lvl[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({cs_n[0], wr_n[0], lvl[0], busy[0]} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
         errors++; $display("FAIL rstmid_async: got cs=%0b wr=%0b lvl=%0d busy=%0b, required 1 1 0 0", cs_n[0], wr_n[0], lvl[0], busy[0]);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      obs.delete();
      repeat (300) @(negedge clk);
      checks++;
      if (obs.size() !== 0 || busy[0] !== 1'b0 || cs_n[0] !== 1'b1) begin
         errors++; $display("FAIL rstmid_quiet: got %0d strobes busy=%0b cs=%0b, required 0 0 1", obs.size(), busy[0], cs_n[0]);
      end
   endtask

   task automatic test_min_counts();
      int p, p0, done;
      do_reset(2);
      push_req(2, 8'h3c, 8'ha5, p);
      wait_idle(100);
      checks++;
      if (obs.size() !== 2 || busy_fall - p !== 9) begin
         errors++; $display("FAIL min_single: got %0d strobes busy drop +%0d, required 2 and +9", obs.size(), busy_fall - p);
      end
      obs.delete();
      p0 = 0;
      for (int i = 0; i < 6; i++) begin
         req_q.push_back('{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))});
         push_req(2, req_q[i].a, req_q[i].d, p);
         if (i == 0) p0 = p;
      end
      done = build_expect(p0 + 1, 1, 1, 1, 0);
      wait_idle(200);
      checks++;
      if (obs.size() !== exp_q.size() || busy_fall !== done) begin
         errors++; $display("FAIL min_count: got %0d strobes busy drop %0d, required %0d and %0d", obs.size(), busy_fall, exp_q.size(), done);
      end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs[i].fall !== exp_q[i].fall || obs[i].rise !== exp_q[i].rise || obs[i].a0 !== exp_q[i].a0 || obs[i].d !== exp_q[i].d) begin
            errors++;
            $display("FAIL min_strobe%0d: got %0d-%0d a0=%0b d=%02h, required %0d-%0d a0=%0b d=%02h", i,
                     obs[i].fall, obs[i].rise, obs[i].a0, obs[i].d, exp_q[i].fall, exp_q[i].rise, exp_q[i].a0, exp_q[i].d);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_skip();
      test_scaled();
      test_reset_mid();
      test_min_counts();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
